// File: rtl/sevenseg_decoder.sv
// Active-low 7-seg bus -> hex nibble after STABLE_CYCLES-sample debounce; SS_DEC_ERR_COUNT_EN adds err_count.
// Latency STABLE_CYCLES+3 edges; valid/ready, a commit while valid&&!ready overwrites data and sets sticky overflow.
module sevenseg_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [6:0] ss_in,
    input  logic       sample_en,
    output logic [3:0] hex_out,
    output logic       blank_out,
    output logic       valid,
    input  logic       ready,
    output logic       illegal,
    output logic       overflow
`ifdef SS_DEC_ERR_COUNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int            CW       = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
    localparam logic [6:0]    SS_BLANK = 7'h7F;

    logic [6:0]    sync1;
    logic [6:0]    ss_s;
    logic [6:0]    cand;
    logic [6:0]    last;
    logic [CW-1:0] cnt;
    logic          commit;
    logic          take;
    logic          dec_legal;
    logic [3:0]    dec_hex;

    // Lamp-test (00) shares the code of digit 8 and is reported as 8.
    always_comb begin
        dec_legal = 1'b1;
        dec_hex   = 4'h0;
        case (cand)
            7'h40: dec_hex = 4'h0;
            7'h79: dec_hex = 4'h1;
            7'h24: dec_hex = 4'h2;
            7'h30: dec_hex = 4'h3;
            7'h19: dec_hex = 4'h4;
            7'h12: dec_hex = 4'h5;
            7'h02: dec_hex = 4'h6;
            7'h78: dec_hex = 4'h7;
            7'h00: dec_hex = 4'h8;
            7'h10: dec_hex = 4'h9;
            7'h08: dec_hex = 4'hA;
            7'h03: dec_hex = 4'hB;
            7'h46: dec_hex = 4'hC;
            7'h21: dec_hex = 4'hD;
            7'h06: dec_hex = 4'hE;
            7'h0E: dec_hex = 4'hF;
            default: dec_legal = 1'b0;
        endcase
    end

    assign commit = sample_en && (ss_s == cand) && (cnt == CNT_MAX) && (cand != last);
    assign take   = commit && (dec_legal || (cand == SS_BLANK));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync1 <= SS_BLANK;
            ss_s  <= SS_BLANK;
        end else begin
            sync1 <= ss_in;
            ss_s  <= sync1;
        end
    end

    // last starts at blank so an idle bus after reset never produces a report.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cand <= SS_BLANK;
            cnt  <= '0;
            last <= SS_BLANK;
        end else if (sample_en) begin
            if (ss_s != cand) begin
                cand <= ss_s;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            if (commit) begin
                last <= cand;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hex_out   <= 4'h0;
            blank_out <= 1'b0;
            valid     <= 1'b0;
            illegal   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            illegal <= commit && !take;
            if (take) begin
                hex_out   <= dec_legal ? dec_hex : 4'h0;
                blank_out <= !dec_legal;
                valid     <= 1'b1;
                if (valid && !ready) begin
                    overflow <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef SS_DEC_ERR_COUNT_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            err_count <= 8'h00;
        end else if (commit && !take && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_sevenseg_decoder.sv
// Bench for sevenseg_decoder: directed scenarios plus randomized bus traffic against a run-length reference model.
module tb_sevenseg_decoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       resetN;
    logic [6:0] ss_in;
    logic       sample_en;
    logic       ready;
    logic [3:0] hex_out;
    logic       blank_out;
    logic       valid;
    logic       illegal;
    logic       overflow;
`ifdef SS_DEC_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    always #5 clk = ~clk;

    sevenseg_decoder #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .ss_in     (ss_in),
        .sample_en (sample_en),
        .hex_out   (hex_out),
        .blank_out (blank_out),
        .valid     (valid),
        .ready     (ready),
        .illegal   (illegal),
        .overflow  (overflow)
`ifdef SS_DEC_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: digit value is the position of the code in this list.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic int lookup(input logic [6:0] code);
        for (int i = 0; i < 16; i++)
            if (seg_tab[i] == code) return i;
        return -1;
    endfunction

    logic [6:0] m_pipe [2];
    logic [6:0] m_hist [$];
    logic [6:0] m_last;
    logic [3:0] m_hex;
    logic       m_blank, m_valid, m_ill, m_ovf;
    int         m_err;

    task automatic model_reset();
        m_pipe[0] = 7'h7F;
        m_pipe[1] = 7'h7F;
        m_hist.delete();
        m_hist.push_back(7'h7F);
        m_last  = 7'h7F;
        m_hex   = 4'h0;
        m_blank = 1'b0;
        m_valid = 1'b0;
        m_ill   = 1'b0;
        m_ovf   = 1'b0;
        m_err   = 0;
    endtask

    // One clock edge: a code is committed once it has been the last S+1 samples in a row and differs from the last commit.
    task automatic model_step();
        logic [6:0] smp;
        logic       nvalid;
        bit         commit;
        int         idx;
        smp    = m_pipe[1];
        nvalid = m_valid && !ready;
        commit = 0;
        m_ill  = 1'b0;
        if (sample_en) begin
            m_hist.push_back(smp);
            if (m_hist.size() > S + 1) void'(m_hist.pop_front());
            if (m_hist.size() == S + 1 && smp != m_last) begin
                commit = 1;
                foreach (m_hist[i]) if (m_hist[i] != smp) commit = 0;
            end
        end
        if (commit) begin
            m_last = smp;
            idx    = lookup(smp);
            if (idx >= 0 || smp == 7'h7F) begin
                if (m_valid && !ready) m_ovf = 1'b1;
                nvalid  = 1'b1;
                m_hex   = (idx >= 0) ? idx[3:0] : 4'h0;
                m_blank = (idx < 0);
            end else begin
                m_ill = 1'b1;
                if (m_err < 255) m_err++;
            end
        end
        m_valid   = nvalid;
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = ss_in;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".hex"},      hex_out,   m_hex);
        check_eq({tag, ".blank"},    blank_out, m_blank);
        check_eq({tag, ".valid"},    valid,     m_valid);
        check_eq({tag, ".illegal"},  illegal,   m_ill);
        check_eq({tag, ".overflow"}, overflow,  m_ovf);
`ifdef SS_DEC_ERR_COUNT_EN
        check_eq({tag, ".err_count"}, err_count, m_err);
`endif
    endtask

    // Inputs are set at a falling edge; the model advances one edge and outputs are checked at the next falling edge.
    task automatic tick(input string tag);
        model_step();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic hold(input logic [6:0] code, input int n, input string tag);
        ss_in = code;
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic apply_reset(input string tag);
        resetN = 1'b0;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    int lat;
    int pulses;
    int saw_valid;

    initial begin
        resetN    = 1'b0;
        ss_in     = 7'h7F;
        sample_en = 1'b1;
        ready     = 1'b1;
        model_reset();
        #12;
        @(negedge clk);
        check_outputs("reset");
        resetN = 1'b1;

        // Idle blank bus never reports.
        hold(7'h7F, 20, "idle");
        check_eq("idle.valid_end", valid, 1'b0);

        // First digit latency, single-cycle valid with ready high.
        ss_in = 7'h24;
        lat   = 0;
        while (!valid && lat < 20) begin
            tick("lat");
            lat++;
        end
        check_eq("latency_edges", lat, S + 3);
        check_eq("lat.hex", hex_out, 4'h2);
        tick("lat_drop");
        check_eq("lat.valid_one_cycle", valid, 1'b0);

        // Short glitch back to the same code produces nothing.
        hold(7'h24, 10, "glitch_pre");
        saw_valid = 0;
        pulses    = 0;
        ss_in = 7'h79;
        for (int i = 0; i < 2; i++) begin tick("glitch"); saw_valid += valid; pulses += illegal; end
        ss_in = 7'h24;
        for (int i = 0; i < 12; i++) begin tick("glitch"); saw_valid += valid; pulses += illegal; end
        check_eq("glitch.no_valid", saw_valid, 0);
        check_eq("glitch.no_illegal", pulses, 0);

        // Overwrite of an unconsumed report.
        ready = 1'b0;
        hold(7'h40, 10, "ovf_a");
        hold(7'h30, 10, "ovf_b");
        check_eq("ovf.hex", hex_out, 4'h3);
        check_eq("ovf.valid", valid, 1'b1);
        check_eq("ovf.flag", overflow, 1'b1);
        ready = 1'b1;
        tick("ovf_drain");
        check_eq("ovf.valid_drop", valid, 1'b0);

        // Illegal code pulses once.
        apply_reset("rst5");
        pulses = 0;
        ss_in  = 7'h55;
        for (int i = 0; i < 14; i++) begin tick("illegal"); pulses += illegal; end
        check_eq("illegal.pulses", pulses, 1);
        check_eq("illegal.valid", valid, 1'b0);

        // Reset mid-count with a pending report, then a fresh digit.
        apply_reset("rst6a");
        ready = 1'b0;
        hold(7'h79, 10, "mid_a");
        hold(7'h30, 5, "mid_b");
        check_eq("mid.valid_before", valid, 1'b1);
        apply_reset("rst6b");
        hold(7'h40, S + 3, "post");
        check_eq("post.valid", valid, 1'b1);
        check_eq("post.hex", hex_out, 4'h0);
        ready = 1'b1;
        tick("post_drain");

        // Randomized traffic: legal, blank, illegal and lamp-test codes with mixed dwell, sample_en and ready.
        for (int blk = 0; blk < 400; blk++) begin
            int sel;
            int dwell;
            sel = $urandom_range(0, 9);
            if (sel < 6)       ss_in = seg_tab[$urandom_range(0, 15)];
            else if (sel < 8)  ss_in = 7'h7F;
            else               ss_in = 7'($urandom);
            dwell = ($urandom_range(0, 3) == 0) ? $urandom_range(1, S) : $urandom_range(S + 2, 14);
            for (int c = 0; c < dwell; c++) begin
                sample_en = ($urandom_range(0, 7) != 0);
                ready     = ($urandom_range(0, 2) != 0);
                tick("rand");
            end
            if ($urandom_range(0, 99) == 0) apply_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
